// File: rtl/tone_arbiter_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tone_arbiter_mux
//  Purpose  : N-channel fixed-priority sound-request arbiter for the single
//             tone generator. Holds each grant for MIN_HOLD ticks and
//             inserts an optional silent gap of GAP_TICKS between tones.
//             All outputs are registered.
//  Option   : TONE_ARB_PREEMPT_EN - when defined, a higher-priority request
//             takes over a playing channel without waiting for the hold.
//  Revision : 1.0 - initial release
// ============================================================================
module tone_arbiter_mux #(
   parameter int NUM_CH    = 4,
   parameter int FREQ_W    = 10,
   parameter int MIN_HOLD  = 3,
   parameter int GAP_TICKS = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           tick,
   input  logic [NUM_CH-1:0]              sound_req,
   input  logic [NUM_CH*FREQ_W-1:0]       tone_freq_in,
   output logic                           sound_enable,
   output logic [FREQ_W-1:0]              tone_freq,
   output logic [$clog2(NUM_CH)-1:0]      active_ch,
   output logic                           grant_pulse
);

   localparam int CH_W    = $clog2(NUM_CH);
   localparam int MAX_CNT = (MIN_HOLD > GAP_TICKS) ? MIN_HOLD : GAP_TICKS;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(MIN_HOLD);
   localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(GAP_TICKS);
   localparam logic [CNT_W-1:0] C_ZERO = '0;
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t              state_q,   state_d;
   logic                enable_q,  enable_d;
   logic [FREQ_W-1:0]   freq_q,    freq_d;
   logic [CH_W-1:0]     chan_q,    chan_d;
   logic                pulse_q,   pulse_d;
   logic [CNT_W-1:0]    hold_q,    hold_d;
   logic [CNT_W-1:0]    gap_q,     gap_d;

   logic                w_any_req;
   logic [CH_W-1:0]     w_winner;
   logic [FREQ_W-1:0]   w_win_freq;
   logic [FREQ_W-1:0]   w_act_freq;
   logic                w_preempt;
   logic                w_grant;

   // Fixed-priority encoder: the lowest requesting index wins.
   always_comb begin
      w_winner = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (sound_req[k]) begin
            w_winner = CH_W'(k);
         end
      end
   end

   assign w_any_req  = |sound_req;
   assign w_win_freq = tone_freq_in[int'(w_winner) * FREQ_W +: FREQ_W];
   assign w_act_freq = tone_freq_in[int'(chan_q)   * FREQ_W +: FREQ_W];

`ifdef TONE_ARB_PREEMPT_EN
   // A strictly higher-priority request may cut in at any time while playing.
   assign w_preempt = (state_q == S_PLAY) && w_any_req && (w_winner < chan_q);
`else
   assign w_preempt = 1'b0;
`endif

   // Next-state and registered-output decode; a grant overrides every other path.
   always_comb begin
      state_d  = state_q;
      enable_d = enable_q;
      freq_d   = freq_q;
      chan_d   = chan_q;
      pulse_d  = 1'b0;
      hold_d   = hold_q;
      gap_d    = gap_q;
      w_grant  = 1'b0;

      case (state_q)
         S_IDLE: begin
            enable_d = 1'b0;
            if (w_any_req) begin
               w_grant = 1'b1;
            end
         end

         S_PLAY: begin
            // Live frequency tracking of the granted channel.
            freq_d = w_act_freq;
            if (tick && (hold_q != C_ZERO)) begin
               hold_d = hold_q - C_ONE;
            end
            if (w_preempt) begin
               w_grant = 1'b1;
            end else if (hold_q == C_ZERO) begin
               if (w_any_req) begin
                  // Winner equal to the active channel means it keeps playing.
                  if (w_winner != chan_q) begin
                     w_grant = 1'b1;
                  end
               end else if (GAP_TICKS > 0) begin
                  state_d  = S_GAP;
                  enable_d = 1'b0;
                  freq_d   = freq_q;
                  gap_d    = C_GAP;
               end else begin
                  state_d  = S_IDLE;
                  enable_d = 1'b0;
                  freq_d   = freq_q;
               end
            end
         end

         S_GAP: begin
            enable_d = 1'b0;
            if (gap_q == C_ZERO) begin
               state_d = S_IDLE;
            end else if (tick) begin
               gap_d = gap_q - C_ONE;
               if (gap_q == C_ONE) begin
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d  = S_IDLE;
            enable_d = 1'b0;
         end
      endcase

      if (w_grant) begin
         state_d  = S_PLAY;
         enable_d = 1'b1;
         chan_d   = w_winner;
         freq_d   = w_win_freq;
         pulse_d  = 1'b1;
         hold_d   = C_HOLD;
         gap_d    = C_ZERO;
      end
   end

   // State, counter and output registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         enable_q <= 1'b0;
         freq_q   <= '0;
         chan_q   <= '0;
         pulse_q  <= 1'b0;
         hold_q   <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         enable_q <= enable_d;
         freq_q   <= freq_d;
         chan_q   <= chan_d;
         pulse_q  <= pulse_d;
         hold_q   <= hold_d;
         gap_q    <= gap_d;
      end
   end

   assign sound_enable = enable_q;
   assign tone_freq    = freq_q;
   assign active_ch    = chan_q;
   assign grant_pulse  = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_arbiter_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_arbiter_mux
//  Purpose  : Directed self-checking bench for tone_arbiter_mux
//             (NUM_CH=4, FREQ_W=10, MIN_HOLD=3, GAP_TICKS=1).
//             Honours TONE_ARB_PREEMPT_EN for the takeover scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tone_arbiter_mux;

   logic        clk;
   logic        reset;
   logic        tick;
   logic [3:0]  sound_req;
   logic [39:0] tone_freq_in;
   logic        sound_enable;
   logic [9:0]  tone_freq;
   logic [1:0]  active_ch;
   logic        grant_pulse;

   int total;
   int bad;

   tone_arbiter_mux #(
      .NUM_CH    (4),
      .FREQ_W    (10),
      .MIN_HOLD  (3),
      .GAP_TICKS (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .sound_req    (sound_req),
      .tone_freq_in (tone_freq_in),
      .sound_enable (sound_enable),
      .tone_freq    (tone_freq),
      .active_ch    (active_ch),
      .grant_pulse  (grant_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic nclk(input int n);
      tick = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tclk();
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic set_freq(input int k, input logic [9:0] v);
      tone_freq_in[k*10 +: 10] = v;
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      reset        = 1'b1;
      tick         = 1'b0;
      sound_req    = 4'b0000;
      tone_freq_in = '0;
      set_freq(0, 10'd50);
      set_freq(1, 10'd200);
      set_freq(2, 10'd300);
      set_freq(3, 10'd100);

      // Reset state
      nclk(3);
      chk("rst_en",    32'(sound_enable), 32'd0);
      chk("rst_freq",  32'(tone_freq),    32'd0);
      chk("rst_ch",    32'(active_ch),    32'd0);
      chk("rst_pulse", 32'(grant_pulse),  32'd0);
      reset = 1'b0;
      nclk(2);
      chk("idle_en", 32'(sound_enable), 32'd0);

      // Single request on ch2, one clock latency
      sound_req = 4'b0100;
      nclk(1);
      chk("g2_en",    32'(sound_enable), 32'd1);
      chk("g2_freq",  32'(tone_freq),    32'd300);
      chk("g2_ch",    32'(active_ch),    32'd2);
      chk("g2_pulse", 32'(grant_pulse),  32'd1);
      tclk();
      chk("g2_pulse_off", 32'(grant_pulse), 32'd0);

      // Higher-priority ch0 arrives one tick into ch2's hold
      sound_req = 4'b0101;
      nclk(1);
`ifdef TONE_ARB_PREEMPT_EN
      chk("pre_ch",    32'(active_ch),   32'd0);
      chk("pre_pulse", 32'(grant_pulse), 32'd1);
      chk("pre_freq",  32'(tone_freq),   32'd50);
`else
      chk("hold_ch",    32'(active_ch),   32'd2);
      chk("hold_pulse", 32'(grant_pulse), 32'd0);
      tclk();
      tclk();
      chk("hold_end_ch", 32'(active_ch),    32'd2);
      chk("hold_end_en", 32'(sound_enable), 32'd1);
      nclk(1);
      chk("take_ch",    32'(active_ch),    32'd0);
      chk("take_pulse", 32'(grant_pulse),  32'd1);
      chk("take_freq",  32'(tone_freq),    32'd50);
      chk("take_en",    32'(sound_enable), 32'd1);
`endif
      nclk(1);
      chk("take_pulse_off", 32'(grant_pulse),  32'd0);
      chk("take_en2",       32'(sound_enable), 32'd1);

      // ch0 released: hold of 3 ticks, then gap, then idle
      sound_req = 4'b0000;
      tclk();
      tclk();
      tclk();
      chk("rel0_en", 32'(sound_enable), 32'd1);
      nclk(1);
      chk("gap0_en", 32'(sound_enable), 32'd0);
      tclk();
      chk("idle0_en", 32'(sound_enable), 32'd0);

      // ch1 single request released after one clock
      sound_req = 4'b0010;
      nclk(1);
      chk("g1_ch",    32'(active_ch),   32'd1);
      chk("g1_freq",  32'(tone_freq),   32'd200);
      chk("g1_pulse", 32'(grant_pulse), 32'd1);
      sound_req = 4'b0000;
      nclk(1);
      chk("g1_en_after_drop", 32'(sound_enable), 32'd1);
      tclk();
      tclk();
      tclk();
      chk("g1_en_3ticks", 32'(sound_enable), 32'd1);
      nclk(1);
      chk("gap1_en",   32'(sound_enable), 32'd0);
      chk("gap1_ch",   32'(active_ch),    32'd1);
      chk("gap1_freq", 32'(tone_freq),    32'd200);
      sound_req = 4'b0010;
      nclk(2);
      chk("gap1_req_wait", 32'(sound_enable), 32'd0);
      tclk();
      chk("gap1_idle_en",    32'(sound_enable), 32'd0);
      chk("gap1_idle_pulse", 32'(grant_pulse),  32'd0);
      nclk(1);
      chk("regrant1_en",    32'(sound_enable), 32'd1);
      chk("regrant1_ch",    32'(active_ch),    32'd1);
      chk("regrant1_pulse", 32'(grant_pulse),  32'd1);

      // ch1 hands over to ch3 without a gap, then ch3 frequency sweep
      sound_req = 4'b1000;
      tclk();
      tclk();
      tclk();
      chk("h13_ch", 32'(active_ch), 32'd1);
      nclk(1);
      chk("g3_ch",    32'(active_ch),    32'd3);
      chk("g3_freq",  32'(tone_freq),    32'd100);
      chk("g3_pulse", 32'(grant_pulse),  32'd1);
      chk("g3_en",    32'(sound_enable), 32'd1);
      nclk(1);
      set_freq(3, 10'd101);
      nclk(1);
      chk("ramp101",       32'(tone_freq),   32'd101);
      chk("ramp101_pulse", 32'(grant_pulse), 32'd0);
      set_freq(3, 10'd102);
      nclk(1);
      chk("ramp102",       32'(tone_freq),   32'd102);
      chk("ramp102_pulse", 32'(grant_pulse), 32'd0);

      // Asynchronous reset between clock edges
      #2;
      reset = 1'b1;
      #1;
      chk("arst_en",   32'(sound_enable), 32'd0);
      chk("arst_freq", 32'(tone_freq),    32'd0);
      chk("arst_ch",   32'(active_ch),    32'd0);
      sound_req = 4'b0000;
      @(posedge clk);
      #1;
      reset = 1'b0;
      nclk(2);
      chk("post_rst_en", 32'(sound_enable), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
